// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage for the MISC-V pipeline.
//
// Holds the ID/EX pipeline register, applies the three forwarding selects and
// drives a combinational ALU for single-cycle ops. An optional iterative
// shift-add multiplier stalls the front end while it runs.
//
// Build option: define EX_MULDIV_EN to build the multiplier and its FSM.
// Without it, op 9 (MUL) returns 0 in one cycle and ex_stall_o is tied low.
//
// Parameters:
//   WIDTH  datapath width (operands, immediate, PC+2, result)
//   RW     width of the rs1/rs2/rd tag fields
//
// Ports:
//   clk_i, reset_ni          rising-edge clock, async active-low reset
//   flush_i                  bubble the ID/EX register, abort any multiply
//   id_*_i                   decode slot: valid, controls, alu op, operands, tags
//   fwd_mem_data_i           forwarded value from MEM
//   fwd_wb_data_i            forwarded value from WB
//   fwd1_sel_i, fwd2_sel_i   0 MEM, 1 WB, 2 registered arg, 3 zero
//   fwd3_sel_i               0 WB, 1 registered arg3
//   ex_stall_o               hold IF/ID and ID/EX while a multiply is busy
//   ex_valid_o               EX holds a valid instruction completing this cycle
//   ex_*_o                   registered controls (qualified by ex_valid_o),
//                            PC+2, ALU result, arg3 and register tags
module ex_stage_mc #(
  parameter int WIDTH = 16,
  parameter int RW    = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic             id_reg_write_i,
  input  logic             id_alu_src_i,
  input  logic             id_mem_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_reg_store_i,
  input  logic [3:0]       id_alu_op_i,
  input  logic [WIDTH-1:0] id_pcp2_i,
  input  logic [WIDTH-1:0] id_arg1_i,
  input  logic [WIDTH-1:0] id_arg2_i,
  input  logic [WIDTH-1:0] id_arg3_i,
  input  logic [WIDTH-1:0] id_imm_i,
  input  logic [RW-1:0]    id_rs1_i,
  input  logic [RW-1:0]    id_rs2_i,
  input  logic [RW-1:0]    id_rd_i,
  input  logic [WIDTH-1:0] fwd_mem_data_i,
  input  logic [WIDTH-1:0] fwd_wb_data_i,
  input  logic [1:0]       fwd1_sel_i,
  input  logic [1:0]       fwd2_sel_i,
  input  logic             fwd3_sel_i,
  output logic             ex_stall_o,
  output logic             ex_valid_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_reg_store_o,
  output logic [WIDTH-1:0] ex_pcp2_o,
  output logic [WIDTH-1:0] ex_alu_result_o,
  output logic [WIDTH-1:0] ex_arg3_o,
  output logic [RW-1:0]    ex_rs1_o,
  output logic [RW-1:0]    ex_rs2_o,
  output logic [RW-1:0]    ex_rd_o
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             alu_src;
    logic             mem_write;
    logic             mem_read;
    logic             reg_store;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] pcp2;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] arg2;
    logic [WIDTH-1:0] arg3;
    logic [WIDTH-1:0] imm;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [RW-1:0]    rd;
  } idex_t;

  idex_t            idex_q, idex_d;
  logic             ex_stall;
  logic [WIDTH-1:0] op1, op2, fwd2_val, arg3_val;
  logic [WIDTH-1:0] alu_res, ex_result;
  logic [SHW-1:0]   shamt;

  // ID/EX register: flush beats stall, stall holds, otherwise load decode.
  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (!ex_stall) begin
      idex_d.valid     = id_valid_i;
      idex_d.reg_write = id_reg_write_i;
      idex_d.alu_src   = id_alu_src_i;
      idex_d.mem_write = id_mem_write_i;
      idex_d.mem_read  = id_mem_read_i;
      idex_d.reg_store = id_reg_store_i;
      idex_d.alu_op    = id_alu_op_i;
      idex_d.pcp2      = id_pcp2_i;
      idex_d.arg1      = id_arg1_i;
      idex_d.arg2      = id_arg2_i;
      idex_d.arg3      = id_arg3_i;
      idex_d.imm       = id_imm_i;
      idex_d.rs1       = id_rs1_i;
      idex_d.rs2       = id_rs2_i;
      idex_d.rd        = id_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // Forwarding muxes.
  always_comb begin
    op1      = '0;
    fwd2_val = '0;
    case (fwd1_sel_i)
      2'd0:    op1 = fwd_mem_data_i;
      2'd1:    op1 = fwd_wb_data_i;
      2'd2:    op1 = idex_q.arg1;
      default: op1 = '0;
    endcase
    case (fwd2_sel_i)
      2'd0:    fwd2_val = fwd_mem_data_i;
      2'd1:    fwd2_val = fwd_wb_data_i;
      2'd2:    fwd2_val = idex_q.arg2;
      default: fwd2_val = '0;
    endcase
  end

  assign op2      = idex_q.alu_src ? idex_q.imm : fwd2_val;
  assign arg3_val = fwd3_sel_i ? idex_q.arg3 : fwd_wb_data_i;
  assign shamt    = op2[SHW-1:0];

  // Single-cycle ALU. MUL and the unused codes fall through to zero; the
  // multiplier result, when built, is substituted below.
  always_comb begin
    alu_res = '0;
    case (idex_q.alu_op)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  // state     | meaning
  // MUL_IDLE  | no multiply running; a valid MUL in EX stalls and starts one
  // MUL_BUSY  | one shift-add per cycle, cnt_q counts 0..WIDTH-1
  // MUL_DONE  | accumulator drives the result for one unstalled cycle
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

  localparam int CW = SHW;

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_in_ex;
  logic             mul_stall;
  logic             mul_done;

  assign mul_in_ex = idex_q.valid && (idex_q.alu_op == OP_MUL);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (mul_in_ex) begin
          mul_stall = 1'b1;
          if (!flush_i) begin
            // Operands are captured once here; forwarding changes later
            // in the multiply cannot disturb it.
            state_d  = MUL_BUSY;
            mcand_d  = op1;
            mplier_d = op2;
            acc_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      MUL_BUSY: begin
        mul_stall = 1'b1;
        if (flush_i) begin
          state_d = MUL_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        mul_done = 1'b1;
        state_d  = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_stall  = mul_stall;
  assign ex_result = mul_done ? acc_q : alu_res;
`else
  assign ex_stall  = 1'b0;
  assign ex_result = alu_res;
`endif

  assign ex_stall_o     = ex_stall;
  assign ex_valid_o     = idex_q.valid & ~ex_stall;
  assign ex_reg_write_o = idex_q.reg_write & ex_valid_o;
  assign ex_mem_write_o = idex_q.mem_write & ex_valid_o;
  assign ex_mem_read_o  = idex_q.mem_read & ex_valid_o;
  assign ex_reg_store_o = idex_q.reg_store & ex_valid_o;

  // Bubbles present zero data so reset leaves every output at 0 regardless
  // of what the forwarding inputs carry.
  assign ex_alu_result_o = idex_q.valid ? ex_result : '0;
  assign ex_arg3_o       = idex_q.valid ? arg3_val : '0;
  assign ex_pcp2_o       = idex_q.pcp2;
  assign ex_rs1_o        = idex_q.rs1;
  assign ex_rs2_o        = idex_q.rs2;
  assign ex_rd_o         = idex_q.rd;

endmodule
